uart_rx_os16: RTL and testbench
===============================

# uart_rx_os16

UART receive stage that consumes the 16x-baud square wave produced by the system frequency divider (153 600 Hz for 9600 baud at a 25 MHz system clock) and recovers serial frames from `rx_in`. It runs entirely on the system clock: the divided clock is synchronized and edge-detected into a one-cycle oversample tick, never used as a clock. Received bytes are presented on a valid/ready interface with per-word error flags.

## Interface
- `DATA_BITS`, 8: data bits per frame (5..9).
- `PARITY_EN`, 0: 1 = one parity bit follows the data.
- `PARITY_ODD`, 0: 1 = odd parity, 0 = even (ignored if `PARITY_EN`=0).
- `clk_in`  in  1  system clock; the block's only clock.
- `rst`  in  1  synchronous, active-high reset.
- `baud_clk_in`  in  1  16x-baud square wave from the divider; asynchronous to `clk_in`; high and low phases each ≥2 `clk_in` cycles.
- `rx_in`  in  1  serial line, idle high, asynchronous.
- `rx_data`  out  DATA_BITS  received word, LSB first on the line.
- `rx_valid`  out  1  word available.
- `rx_ready`  in  1  consumer accepts the word.
- `frame_err`  out  1  stop bit sampled low; qualified by `rx_valid`.
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`.
- `overrun`  out  1  at least one frame was dropped while `rx_valid` was held.
- `busy`  out  1  state ≠ IDLE.

## Operation
- 2-FF synchronizers on `baud_clk_in` (reset 0) and `rx_in` (reset 1). `tick` = rising edge of the synchronized baud clock, one `clk_in` cycle wide.
- `line_prev` holds `rx_s` as sampled at the previous tick (reset 1).
- States: IDLE, START, DATA, PARITY, STOP. `os_cnt` 4 bits, `bit_cnt` 4 bits. All actions below occur only on `tick` cycles.
- IDLE: `rx_s`=0 and `line_prev`=1 → START, `os_cnt`←0. A line held low (break, post-frame-error) never retriggers without first returning high.
- START: `os_cnt`++; at `os_cnt`==7, sample: low → DATA, `os_cnt`←0, `bit_cnt`←0; high → IDLE (glitch rejected, no output).
- DATA: `os_cnt`++; at `os_cnt`==15, shift `rx_s` into the MSB of the shift register (right shift), `os_cnt`←0, `bit_cnt`++; after the `DATA_BITS`-th sample → PARITY if `PARITY_EN`, else STOP.
- PARITY: at `os_cnt`==15, capture bit; `perr` = XOR(data, bit) ≠ `PARITY_ODD`.
- STOP: at `os_cnt`==15, sample; low → `frame_err`. Deliver the word and go to IDLE in the same cycle.
- Delivery: if `rx_valid`=0, or `rx_valid`&`rx_ready` in that cycle → load `rx_data`/`frame_err`/`parity_err`, `rx_valid`←1. Otherwise, the new word is discarded, held data is unchanged, and `overrun`←1.
- `rx_valid`&`rx_ready` with no simultaneous delivery → `rx_valid`←0 and `overrun`←0 next cycle. `overrun` is sticky until the held word is accepted.
- Reset: state IDLE; `rx_data`, `rx_valid`, `frame_err`, `parity_err`, `overrun`, and `busy` all 0; counters 0. Reset mid-frame aborts the frame with no output.

## Timing
- `tick` is asserted 2–3 `clk_in` cycles after a `baud_clk_in` rising edge.
- Start-bit sample: 8 ticks after detection. Each following bit is sampled 16 ticks later.
- Start detection to stop sample: 8 + 16·(DATA_BITS + PARITY_EN + 1) ticks (8N1: 152 ticks).
- `rx_valid` rises on the `clk_in` edge after the stop-sample tick cycle. It stays high until the handshake; there is no timeout.
- No combinational path from `rx_ready` to any output.
- Next start detection is possible from the tick after the stop sample (half-bit stop tolerance).

## Structure
- Package `uart_pkg`:
  - state enum;
  - `OS_RATE`=16, `OS_MID`=7;
  - `CLK_FREQ`=25 000 000 and `BAUD`=9600, shared with the divider.
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge pulse, used for `baud_clk_in`. `rx_in` uses the synchronizer path only.

## Test plan
- 8N1, `rx_ready`=1, send 0x55 → `rx_data`=0x55, `rx_valid` high for one cycle, all flags 0, 152 ticks from start edge.
- `rx_in` low for 4 ticks, then high → no `rx_valid`; `busy` returns to 0 at the 8th tick. A following 0x3C frame is received correctly.
- Send 0xA3 with stop=0, then hold the line low for 3 bit times → `rx_data`=0xA3, `frame_err`=1. No second frame until the line goes high then falls.
- `rx_ready`=0, send 0x12 then 0x34 → `rx_data`=0x12, `overrun`=1. Raise `rx_ready` → `rx_valid` and `overrun` drop next cycle.
- `PARITY_EN`=1, even parity:
  - 0x07 with parity bit 1 → `parity_err`=0;
  - 0x07 with parity bit 0 → `parity_err`=1.
- Assert `rst` for one cycle during data bit 4 → outputs 0, state IDLE; next frame 0xC3 received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, oversampling constants,
// and the clock/baud figures used by the frequency divider.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int unsigned OS_RATE  = 16;
   localparam int unsigned OS_MID   = 7;
   localparam int unsigned CLK_FREQ = 25_000_000;
   localparam int unsigned BAUD     = 9600;

endpackage

// File: rtl/uart_rx_os16_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a
// one-cycle pulse on each rising edge of the synchronized level.
module sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_in,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise
);

   logic [1:0] ff;
   logic       prev;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         ff   <= {2{RST_VAL}};
         prev <= RST_VAL;
      end else begin
         ff   <= {ff[0], din};
         prev <= ff[1];
      end
   end

   assign sync = ff[1];
   assign rise = ff[1] & ~prev;

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver on the system clock; the divided
// baud clock only produces an enable tick, never a clock.
module uart_rx_os16
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter bit          PARITY_EN  = 1'b0,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic                 clk_in,
   input  logic                 rst,
   input  logic                 baud_clk_in,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam logic [3:0] OS_LAST  = 4'(OS_RATE - 1);
   localparam logic [3:0] OS_HALF  = 4'(OS_MID);
   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   rx_state_t            state, state_n;
   logic [3:0]           os_cnt, os_n;
   logic [3:0]           bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shreg, sh_n;
   logic                 perr, perr_n;
   logic                 tick, baud_s;
   logic [1:0]           rx_ff;
   logic                 rx_s, line_prev;
   logic                 deliver, ferr_new;

   sync_edge #(.RST_VAL(1'b0)) u_baud (
      .clk_in (clk_in),
      .rst    (rst),
      .din    (baud_clk_in),
      .sync   (baud_s),
      .rise   (tick)
   );

   assign rx_s = rx_ff[1];
   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         rx_ff     <= 2'b11;
         line_prev <= 1'b1;
         state     <= ST_IDLE;
         os_cnt    <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         perr      <= 1'b0;
      end else begin
         rx_ff     <= {rx_ff[0], rx_in};
         if (tick) line_prev <= rx_s;
         state     <= state_n;
         os_cnt    <= os_n;
         bit_cnt   <= bit_n;
         shreg     <= sh_n;
         perr      <= perr_n;
      end
   end

   always_comb begin
      state_n  = state;
      os_n     = os_cnt;
      bit_n    = bit_cnt;
      sh_n     = shreg;
      perr_n   = perr;
      deliver  = 1'b0;
      ferr_new = 1'b0;
      if (tick) begin
         unique case (state)
            ST_IDLE: begin
               // Falling edge only: a line stuck low never retriggers
               if (!rx_s && line_prev) begin
                  state_n = ST_START;
                  os_n    = '0;
               end
            end
            ST_START: begin
               if (os_cnt == OS_HALF) begin
                  os_n    = '0;
                  bit_n   = '0;
                  perr_n  = 1'b0;
                  state_n = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  os_n = os_cnt + 4'd1;
               end
            end
            ST_DATA: begin
               if (os_cnt == OS_LAST) begin
                  sh_n  = {rx_s, shreg[DATA_BITS-1:1]};
                  os_n  = '0;
                  bit_n = bit_cnt + 4'd1;
                  if (bit_cnt == LAST_BIT)
                     state_n = PARITY_EN ? ST_PARITY : ST_STOP;
               end else begin
                  os_n = os_cnt + 4'd1;
               end
            end
            ST_PARITY: begin
               if (os_cnt == OS_LAST) begin
                  perr_n  = ((^shreg) ^ rx_s) != PARITY_ODD;
                  os_n    = '0;
                  state_n = ST_STOP;
               end else begin
                  os_n = os_cnt + 4'd1;
               end
            end
            ST_STOP: begin
               if (os_cnt == OS_LAST) begin
                  deliver  = 1'b1;
                  ferr_new = ~rx_s;
                  os_n     = '0;
                  state_n  = ST_IDLE;
               end else begin
                  os_n = os_cnt + 4'd1;
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else if (deliver) begin
         // A held word that is not being taken this cycle wins
         if (!rx_valid || rx_ready) begin
            rx_data    <= shreg;
            frame_err  <= ferr_new;
            parity_err <= perr;
            rx_valid   <= 1'b1;
            overrun    <= 1'b0;
         end else begin
            overrun <= 1'b1;
         end
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench: 8N1 receiver and an 8E1 receiver driven from
// one stimulus line, checked with immediate assertions.
module tb_uart_rx_os16;

   logic clk_in   = 1'b0;
   logic rst      = 1'b1;
   logic baud_clk = 1'b0;
   logic line     = 1'b1;
   logic sel_p    = 1'b0;
   logic ready    = 1'b1;
   logic rx_a, rx_b;

   logic [7:0] data_a, data_b;
   logic valid_a, fe_a, pe_a, ovr_a, busy_a;
   logic valid_b, fe_b, pe_b, ovr_b, busy_b;

   int unsigned total = 0;
   int unsigned fails = 0;

   always #5 clk_in = ~clk_in;
   initial begin
      #3;
      forever #37 baud_clk = ~baud_clk;
   end

   assign rx_a = sel_p ? 1'b1 : line;
   assign rx_b = sel_p ? line : 1'b1;

   uart_rx_os16 dut_a (
      .clk_in     (clk_in),
      .rst        (rst),
      .baud_clk_in(baud_clk),
      .rx_in      (rx_a),
      .rx_data    (data_a),
      .rx_valid   (valid_a),
      .rx_ready   (ready),
      .frame_err  (fe_a),
      .parity_err (pe_a),
      .overrun    (ovr_a),
      .busy       (busy_a)
   );

   uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
      .clk_in     (clk_in),
      .rst        (rst),
      .baud_clk_in(baud_clk),
      .rx_in      (rx_b),
      .rx_data    (data_b),
      .rx_valid   (valid_b),
      .rx_ready   (ready),
      .frame_err  (fe_b),
      .parity_err (pe_b),
      .overrun    (ovr_b),
      .busy       (busy_b)
   );

   int unsigned edge_cnt   = 0;
   int unsigned start_edge = 0;
   always @(posedge baud_clk) edge_cnt++;

   int unsigned va_cnt = 0, va_cycles = 0, va_lat = 0;
   logic [7:0]  va_data = '0;
   logic        va_fe = 1'b0, va_pe = 1'b0, va_prev = 1'b0;
   int unsigned vb_cnt = 0;
   logic [7:0]  vb_data = '0;
   logic        vb_pe = 1'b0, vb_fe = 1'b0, vb_prev = 1'b0;

   always @(negedge clk_in) begin
      if (valid_a) begin
         va_cycles++;
         if (!va_prev) begin
            va_cnt++;
            va_data = data_a;
            va_fe   = fe_a;
            va_pe   = pe_a;
            va_lat  = edge_cnt - start_edge;
         end
      end
      va_prev = valid_a;
      if (valid_b && !vb_prev) begin
         vb_cnt++;
         vb_data = data_b;
         vb_fe   = fe_b;
         vb_pe   = pe_b;
      end
      vb_prev = valid_b;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic b);
      line = b;
      repeat (16) @(negedge baud_clk);
   endtask

   task automatic send(input logic [7:0] d, input logic has_par,
                       input logic par, input logic stop);
      @(negedge baud_clk);
      start_edge = edge_cnt;
      put(1'b0);
      for (int i = 0; i < 8; i++) put(d[i]);
      if (has_par) put(par);
      put(stop);
   endtask

   int unsigned base;

   initial begin
      repeat (4) @(posedge clk_in);
      @(negedge clk_in);
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_data", 32'(data_a), 32'h00);
      chk("rst_ferr", 32'(fe_a), 32'd0);
      chk("rst_perr", 32'(pe_a), 32'd0);
      chk("rst_ovr", 32'(ovr_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      rst = 1'b0;
      repeat (32) @(negedge baud_clk);

      // 8N1 0x55; detection edge counted, so 152 ticks shows as 153 edges
      va_cycles = 0;
      send(8'h55, 1'b0, 1'b0, 1'b1);
      chk("t1_cnt", va_cnt, 32'd1);
      chk("t1_data", 32'(va_data), 32'h55);
      chk("t1_cycles", va_cycles, 32'd1);
      chk("t1_ferr", 32'(va_fe), 32'd0);
      chk("t1_perr", 32'(va_pe), 32'd0);
      chk("t1_lat", va_lat, 32'd153);
      chk("t1_ovr", 32'(ovr_a), 32'd0);

      // start glitch of 4 ticks
      base = va_cnt;
      @(negedge baud_clk);
      line = 1'b0;
      repeat (4) @(negedge baud_clk);
      line = 1'b1;
      repeat (4) @(posedge baud_clk);
      #60;
      chk("t2_busy_hi", 32'(busy_a), 32'd1);
      @(posedge baud_clk);
      #60;
      chk("t2_busy_lo", 32'(busy_a), 32'd0);
      repeat (32) @(negedge baud_clk);
      chk("t2_none", va_cnt, base);
      send(8'h3C, 1'b0, 1'b0, 1'b1);
      chk("t2_cnt", va_cnt, base + 1);
      chk("t2_data", 32'(va_data), 32'h3C);

      // framing error, then line held low
      repeat (16) @(negedge baud_clk);
      base = va_cnt;
      send(8'hA3, 1'b0, 1'b0, 1'b0);
      repeat (48) @(negedge baud_clk);
      chk("t3_cnt", va_cnt, base + 1);
      chk("t3_data", 32'(va_data), 32'hA3);
      chk("t3_ferr", 32'(va_fe), 32'd1);
      chk("t3_busy", 32'(busy_a), 32'd0);
      line = 1'b1;
      repeat (32) @(negedge baud_clk);

      // overrun with consumer stalled
      ready = 1'b0;
      base = va_cnt;
      send(8'h12, 1'b0, 1'b0, 1'b1);
      send(8'h34, 1'b0, 1'b0, 1'b1);
      repeat (4) @(negedge baud_clk);
      chk("t4_valid", 32'(valid_a), 32'd1);
      chk("t4_data", 32'(data_a), 32'h12);
      chk("t4_ovr", 32'(ovr_a), 32'd1);
      chk("t4_cnt", va_cnt, base + 1);
      @(negedge clk_in);
      ready = 1'b1;
      @(posedge clk_in);
      #1;
      chk("t4_valid_drop", 32'(valid_a), 32'd0);
      chk("t4_ovr_drop", 32'(ovr_a), 32'd0);

      // even parity on the 8E1 receiver
      sel_p = 1'b1;
      repeat (32) @(negedge baud_clk);
      send(8'h07, 1'b1, 1'b1, 1'b1);
      chk("t5_cnt_a", vb_cnt, 32'd1);
      chk("t5_data_a", 32'(vb_data), 32'h07);
      chk("t5_perr_a", 32'(vb_pe), 32'd0);
      send(8'h07, 1'b1, 1'b0, 1'b1);
      chk("t5_cnt_b", vb_cnt, 32'd2);
      chk("t5_perr_b", 32'(vb_pe), 32'd1);
      chk("t5_ferr_b", 32'(vb_fe), 32'd0);
      sel_p = 1'b0;
      repeat (32) @(negedge baud_clk);

      // reset pulse during data bit 4
      base = va_cnt;
      @(negedge baud_clk);
      put(1'b0);
      put(1'b1);
      put(1'b0);
      put(1'b1);
      put(1'b0);
      line = 1'b1;
      repeat (8) @(negedge baud_clk);
      chk("t6_busy_pre", 32'(busy_a), 32'd1);
      @(negedge clk_in);
      rst = 1'b1;
      @(negedge clk_in);
      rst = 1'b0;
      chk("t6_busy", 32'(busy_a), 32'd0);
      chk("t6_valid", 32'(valid_a), 32'd0);
      chk("t6_data", 32'(data_a), 32'h00);
      chk("t6_ovr", 32'(ovr_a), 32'd0);
      repeat (48) @(negedge baud_clk);
      chk("t6_none", va_cnt, base);
      send(8'hC3, 1'b0, 1'b0, 1'b1);
      chk("t6_cnt", va_cnt, base + 1);
      chk("t6_rx", 32'(va_data), 32'hC3);
      chk("t6_ferr", 32'(va_fe), 32'd0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
